pipe_stage_chain: RTL and testbench
===================================

PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 32, meaning payload width in bits (legal 1..128).
REQ-002 The block SHALL expose parameter STAGES, default 3, meaning number of register stages in the chain (legal 1..8).
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port in_valid  input  1  upstream offers in_data this cycle.
REQ-006 The block SHALL have port in_ready  output  1  stage 0 can accept this cycle.
REQ-007 The block SHALL have port in_data  input  DATA_W  payload from upstream.
REQ-008 The block SHALL have port out_valid  output  1  last stage holds a valid payload.
REQ-009 The block SHALL have port out_ready  input  1  downstream accepts this cycle.
REQ-010 The block SHALL have port out_data  output  DATA_W  payload of the last stage.
REQ-011 The block SHALL have port flush_mask  input  STAGES  bit i invalidates stage i (bit 0 = stage nearest input).
REQ-012 The block SHALL have port stage_valid  output  STAGES  per-stage valid bits, for hazard detection.
REQ-013 The block SHALL have port occupancy  output  $clog2(STAGES+1)  count of valid stages.

Function
REQ-014 Each stage i SHALL hold a valid bit v[i] and a DATA_W data register d[i].
REQ-015 Stage i SHALL be ready when v[i]=0 or stage i+1 is ready; the last stage's successor readiness SHALL be out_ready.
REQ-016 in_ready SHALL equal stage-0 readiness, combinationally, with no dependency on in_valid.
REQ-017 Stage i SHALL load d[i-1] (in_data for i=0) and v[i-1] (in_valid for i=0) when ready; otherwise it SHALL hold both.
REQ-018 Data registers SHALL only load when the incoming valid is 1; a bubble SHALL clear v[i] without changing d[i].
REQ-019 With in_valid=1 and out_ready=1 continuously, latency in->out SHALL be STAGES cycles and throughput one item per cycle.
REQ-020 When out_ready=0 and all stages are valid, in_ready SHALL be 0 and every stage SHALL hold (full stall, no loss, no duplication).
REQ-021 Bubbles SHALL collapse: an invalid stage SHALL accept from upstream even while downstream is stalled.
REQ-022 When flush_mask[i]=1, v[i] SHALL be 0 after the edge, overriding any capture into stage i that cycle; the item that would have entered is discarded.
REQ-023 A flushed stage SHALL still present as ready in that cycle, so its predecessor advances.
REQ-024 out_valid SHALL equal v[STAGES-1]; out_data SHALL equal d[STAGES-1]; stage_valid SHALL equal v.
REQ-025 occupancy SHALL equal the population count of v, as a registered or combinational function of v, never exceeding STAGES.
REQ-026 With STAGES=1, the block SHALL degenerate to a single elastic register with identical rules.

Reset
REQ-027 Asserting rst SHALL immediately clear all v[i]; out_valid, stage_valid and occupancy SHALL read 0 while rst is high.
REQ-028 Data registers SHALL reset to 0.
REQ-029 Items in flight when rst asserts SHALL be lost; the first edge after deassertion SHALL behave as from an empty chain.

Structure
REQ-030 Default DATA_W and STAGES constants SHALL live in the shared pipeline package, alongside the other pipeline-register widths.
REQ-031 One sub-module, pipe_stage (one valid+data register with ready logic and flush), SHALL be instantiated STAGES times via a generate loop.

Verification
REQ-032 Stream: STAGES=3, in_data 1,2,3,4 on consecutive cycles, out_ready=1 -> out_data 1,2,3,4 on cycles 3..6 with out_valid=1.
REQ-033 Backpressure: fill 3 items (0xA,0xB,0xC), out_ready=0 for 4 cycles -> in_ready=0, occupancy=3, out_data held at 0xA; release -> A,B,C in order.
REQ-034 Bubble collapse: items at stages 0 and 2 only, out_ready=0 -> next edge stage 1 valid, occupancy stays 2.
REQ-035 Flush: chain full with 5,6,7, flush_mask=3'b011 with in_valid=1 data 8 -> after edge only stage 2 (value 5) valid, item 8 discarded, occupancy=1.
REQ-036 Reset mid-stream: rst pulsed between edges while full -> out_valid=0 before next edge, occupancy=0; fresh stream afterwards delivers correctly.
REQ-037 Parameter sweep: STAGES=1 and 8, DATA_W=8 and 64, random valid/ready/flush -> scoreboard shows order preserved, no duplicates, only flushed items missing.

Source files
------------

// File: rtl/pipe_stage_chain_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_chain_pkg
// Description : Shared pipeline constants and the valid-count helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_stage_chain_pkg;

    localparam int c_DEFAULT_DATA_W = 32;
    localparam int c_DEFAULT_STAGES = 3;
    localparam int c_MAX_DATA_W     = 128;
    localparam int c_MAX_STAGES     = 8;
    localparam int c_OCC_W_MAX      = $clog2(c_MAX_STAGES + 1);

    // Population count over the widest legal chain; callers zero-extend.
    function automatic logic [c_OCC_W_MAX-1:0] count_valid(
        input logic [c_MAX_STAGES-1:0] v
    );
        logic [c_OCC_W_MAX-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < c_MAX_STAGES; i++) begin
            cnt = cnt + c_OCC_W_MAX'(v[i]);
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_chain_stage.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage
// Description : One elastic valid+data register with ready chaining and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage
    import pipe_stage_chain_pkg::*;
#(
    parameter int DATA_W = c_DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_up_valid,
    input  logic [DATA_W-1:0] i_up_data,
    input  logic              i_down_ready,
    input  logic              i_flush,
    output logic              o_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              w_ready;

    // A flushed stage empties this edge, so it can always take from upstream.
    assign w_ready = !r_valid || i_down_ready || i_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            if (i_flush) begin
                r_valid <= 1'b0;
            end else if (w_ready) begin
                r_valid <= i_up_valid;
            end
            if (w_ready && i_up_valid) begin
                r_data <= i_up_data;
            end
        end
    end

    assign o_ready = w_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_chain.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_chain
// Description : STAGES-deep elastic register chain with bubble collapse,
//               per-stage flush and occupancy reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_chain
    import pipe_stage_chain_pkg::*;
#(
    parameter int DATA_W = c_DEFAULT_DATA_W,
    parameter int STAGES = c_DEFAULT_STAGES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    input  logic [STAGES-1:0]            flush_mask,
    output logic [STAGES-1:0]            stage_valid,
    output logic [$clog2(STAGES+1)-1:0]  occupancy
);

    logic [STAGES-1:0]       w_valid;
    logic [STAGES:0]         w_ready;
    logic [DATA_W-1:0]       w_data [STAGES];
    logic [c_MAX_STAGES-1:0] w_valid_ext;
    logic [c_OCC_W_MAX-1:0]  w_count;

    // w_ready[STAGES] is the successor readiness of the last stage.
    assign w_ready[STAGES] = out_ready;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic              w_up_valid;
        logic [DATA_W-1:0] w_up_data;

        if (i == 0) begin : g_first
            assign w_up_valid = in_valid;
            assign w_up_data  = in_data;
        end else begin : g_rest
            assign w_up_valid = w_valid[i-1];
            assign w_up_data  = w_data[i-1];
        end

        pipe_stage #(
            .DATA_W (DATA_W)
        ) u_stage (
            .clk          (clk),
            .rst          (rst),
            .i_up_valid   (w_up_valid),
            .i_up_data    (w_up_data),
            .i_down_ready (w_ready[i+1]),
            .i_flush      (flush_mask[i]),
            .o_ready      (w_ready[i]),
            .o_valid      (w_valid[i]),
            .o_data       (w_data[i])
        );
    end

    always_comb begin
        w_valid_ext             = '0;
        w_valid_ext[STAGES-1:0] = w_valid;
    end

    assign w_count     = count_valid(w_valid_ext);
    assign occupancy   = w_count[$clog2(STAGES+1)-1:0];
    assign in_ready    = w_ready[0];
    assign out_valid   = w_valid[STAGES-1];
    assign out_data    = w_data[STAGES-1];
    assign stage_valid = w_valid;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_chain.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_chain
// Description : Directed vectors plus randomized model comparison over three
//               chain configurations (3x32, 1x8, 8x64).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_chain;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv;
    logic        ordy;
    logic [63:0] idata;
    logic [7:0]  fl;

    always #5 clk = ~clk;

    logic        a_ir, a_ov;  logic [31:0] a_od;  logic [2:0] a_sv;  logic [1:0] a_occ;
    logic        b_ir, b_ov;  logic [7:0]  b_od;  logic [0:0] b_sv;  logic [0:0] b_occ;
    logic        c_ir, c_ov;  logic [63:0] c_od;  logic [7:0] c_sv;  logic [3:0] c_occ;

    pipe_stage_chain #(.DATA_W(32), .STAGES(3)) u_dut (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(a_ir), .in_data(idata[31:0]),
        .out_valid(a_ov), .out_ready(ordy), .out_data(a_od), .flush_mask(fl[2:0]),
        .stage_valid(a_sv), .occupancy(a_occ));

    pipe_stage_chain #(.DATA_W(8), .STAGES(1)) u_s1 (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(b_ir), .in_data(idata[7:0]),
        .out_valid(b_ov), .out_ready(ordy), .out_data(b_od), .flush_mask(fl[0:0]),
        .stage_valid(b_sv), .occupancy(b_occ));

    pipe_stage_chain #(.DATA_W(64), .STAGES(8)) u_s8 (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(c_ir), .in_data(idata),
        .out_valid(c_ov), .out_ready(ordy), .out_data(c_od), .flush_mask(fl),
        .stage_valid(c_sv), .occupancy(c_occ));

    // Observed outputs of whichever instance is under random test
    int          sel;
    logic        o_ir, o_ov;
    logic [63:0] o_od;
    logic [7:0]  o_sv;
    int          o_occ;

    always_comb begin
        o_ir = a_ir; o_ov = a_ov; o_od = 64'(a_od); o_sv = 8'(a_sv); o_occ = int'(a_occ);
        case (sel)
            1: begin o_ir = b_ir; o_ov = b_ov; o_od = 64'(b_od); o_sv = 8'(b_sv); o_occ = int'(b_occ); end
            2: begin o_ir = c_ir; o_ov = c_ov; o_od = c_od;      o_sv = c_sv;     o_occ = int'(c_occ); end
            default: ;
        endcase
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic cyc(input logic v, input logic [63:0] d, input logic r, input logic [7:0] f);
        iv = v; idata = d; ordy = r; fl = f;
        @(posedge clk); #1;
    endtask

    // Directed vector table for the 3-stage instance: inputs, then outputs
    // expected before the edge that consumes those inputs.
    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        r;
        logic        exp_ir;
        logic        exp_ov;
        logic [31:0] exp_od;
        int          exp_occ;
    } vec_t;

    function automatic vec_t mk(logic v, logic [31:0] d, logic r, logic eir, logic eov,
                                logic [31:0] eod, int eocc);
        vec_t t;
        t.v = v; t.d = d; t.r = r; t.exp_ir = eir; t.exp_ov = eov; t.exp_od = eod; t.exp_occ = eocc;
        return t;
    endfunction

    // Behavioural model: a stage advances iff some stage at or beyond it is
    // empty or flushed, or the consumer is taking.
    bit          mv [8];
    logic [63:0] md [8];

    task automatic run_random(input int s, input int n, input logic [63:0] mask, input int cycles);
        bit          rdy [8];
        logic [7:0]  esv;
        int          eocc;
        logic [31:0] seq;
        logic [31:0] last;
        sel = s;
        rst = 1'b1; iv = 1'b0; ordy = 1'b0; fl = '0; idata = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin mv[i] = 0; md[i] = '0; end
        seq = 32'd1; last = 32'd0;
        repeat (cycles) begin
            iv    = ($urandom % 10) < 7;
            ordy  = ($urandom % 10) < 6;
            fl    = (($urandom % 8) == 0) ? 8'($urandom) : 8'h00;
            idata = {$urandom, seq};
            seq   = seq + 1;
            #1;
            esv = '0; eocc = 0;
            for (int i = 0; i < n; i++) begin
                rdy[i] = ordy;
                for (int j = i; j < n; j++) if (!mv[j] || fl[j]) rdy[i] = 1;
                esv[i] = mv[i];
                eocc   += int'(mv[i]);
            end
            check("rnd_in_ready",  64'(o_ir),  64'(rdy[0]));
            check("rnd_out_valid", 64'(o_ov),  64'(mv[n-1]));
            check("rnd_stage_vld", 64'(o_sv),  64'(esv));
            check("rnd_occupancy", 64'(o_occ), 64'(eocc));
            if (mv[n-1]) check("rnd_out_data", o_od, md[n-1]);
            if (s != 1 && o_ov && ordy) begin
                check("rnd_order", 64'(o_od[31:0] > last), 64'd1);
                last = o_od[31:0];
            end
            @(posedge clk);
            for (int i = n - 1; i >= 0; i--) begin
                if (fl[i]) mv[i] = 0;
                else if (rdy[i]) begin
                    if (i == 0) begin
                        mv[0] = iv;
                        if (iv) md[0] = idata & mask;
                    end else begin
                        if (mv[i-1]) md[i] = md[i-1];
                        mv[i] = mv[i-1];
                    end
                end
            end
            #1;
        end
    endtask

    vec_t tbl [19];

    initial begin
        sel = 0;
        rst = 1'b1; iv = 1'b0; ordy = 1'b0; fl = '0; idata = '0;

        // Stream 1..4 (out on rows 3..6), then fill A,B,C and stall 4 cycles
        tbl[0]  = mk(1, 32'h1, 1, 1, 0, 32'h0, 0);
        tbl[1]  = mk(1, 32'h2, 1, 1, 0, 32'h0, 1);
        tbl[2]  = mk(1, 32'h3, 1, 1, 0, 32'h0, 2);
        tbl[3]  = mk(1, 32'h4, 1, 1, 1, 32'h1, 3);
        tbl[4]  = mk(0, 32'h0, 1, 1, 1, 32'h2, 3);
        tbl[5]  = mk(0, 32'h0, 1, 1, 1, 32'h3, 2);
        tbl[6]  = mk(0, 32'h0, 1, 1, 1, 32'h4, 1);
        tbl[7]  = mk(0, 32'h0, 1, 1, 0, 32'h0, 0);
        tbl[8]  = mk(1, 32'hA, 0, 1, 0, 32'h0, 0);
        tbl[9]  = mk(1, 32'hB, 0, 1, 0, 32'h0, 1);
        tbl[10] = mk(1, 32'hC, 0, 1, 0, 32'h0, 2);
        tbl[11] = mk(1, 32'hD, 0, 0, 1, 32'hA, 3);
        tbl[12] = mk(1, 32'hD, 0, 0, 1, 32'hA, 3);
        tbl[13] = mk(1, 32'hD, 0, 0, 1, 32'hA, 3);
        tbl[14] = mk(1, 32'hD, 0, 0, 1, 32'hA, 3);
        tbl[15] = mk(0, 32'h0, 1, 1, 1, 32'hA, 3);
        tbl[16] = mk(0, 32'h0, 1, 1, 1, 32'hB, 2);
        tbl[17] = mk(0, 32'h0, 1, 1, 1, 32'hC, 1);
        tbl[18] = mk(0, 32'h0, 0, 1, 0, 32'h0, 0);

        @(posedge clk); #1;
        check("reset_out_valid", 64'(a_ov),  64'd0);
        check("reset_occupancy", 64'(a_occ), 64'd0);
        check("reset_stage_vld", 64'(a_sv),  64'd0);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            iv = tbl[i].v; idata = 64'(tbl[i].d); ordy = tbl[i].r; fl = '0;
            #1;
            check($sformatf("tbl%0d_in_ready", i),  64'(a_ir),  64'(tbl[i].exp_ir));
            check($sformatf("tbl%0d_out_valid", i), 64'(a_ov),  64'(tbl[i].exp_ov));
            check($sformatf("tbl%0d_occupancy", i), 64'(a_occ), 64'(tbl[i].exp_occ));
            if (tbl[i].exp_ov) check($sformatf("tbl%0d_out_data", i), 64'(a_od), 64'(tbl[i].exp_od));
            @(posedge clk); #1;
        end

        // Bubble collapse: items in stages 0 and 2, downstream stalled
        cyc(1, 64'h11, 0, 8'h0);
        cyc(0, 64'h0,  0, 8'h0);
        cyc(1, 64'h22, 0, 8'h0);
        check("bubble_pre_sv",  64'(a_sv),  64'b101);
        check("bubble_pre_occ", 64'(a_occ), 64'd2);
        cyc(0, 64'h0, 0, 8'h0);
        check("bubble_post_sv",  64'(a_sv),  64'b110);
        check("bubble_post_occ", 64'(a_occ), 64'd2);
        check("bubble_post_od",  64'(a_od),  64'h11);

        // Drain, then fill with 5,6,7 and flush stages 0 and 1 while offering 8
        repeat (3) cyc(0, 64'h0, 1, 8'h0);
        check("drain_occ", 64'(a_occ), 64'd0);
        cyc(1, 64'h5, 0, 8'h0);
        cyc(1, 64'h6, 0, 8'h0);
        cyc(1, 64'h7, 0, 8'h0);
        check("full_sv", 64'(a_sv), 64'b111);
        iv = 1'b1; idata = 64'h8; ordy = 1'b0; fl = 8'b011;
        #1;
        check("flush_in_ready", 64'(a_ir), 64'd1);
        @(posedge clk); #1;
        iv = 1'b0; fl = '0;
        check("flush_sv",  64'(a_sv),  64'b100);
        check("flush_occ", 64'(a_occ), 64'd1);
        check("flush_od",  64'(a_od),  64'h5);
        cyc(0, 64'h0, 0, 8'h0);
        check("flush_hold_sv", 64'(a_sv), 64'b100);

        // Reset pulsed between edges while full, then a fresh stream
        cyc(1, 64'h21, 0, 8'h0);
        cyc(1, 64'h22, 0, 8'h0);
        check("prerst_occ", 64'(a_occ), 64'd3);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(a_ov),  64'd0);
        check("midrst_occupancy", 64'(a_occ), 64'd0);
        check("midrst_stage_vld", 64'(a_sv),  64'd0);
        #1 rst = 1'b0;
        cyc(1, 64'h31, 1, 8'h0);
        cyc(1, 64'h32, 1, 8'h0);
        cyc(1, 64'h33, 1, 8'h0);
        iv = 1'b0;
        #1;
        check("postrst_ov0", 64'(a_ov), 64'd1);
        check("postrst_od0", 64'(a_od), 64'h31);
        @(posedge clk); #1;
        check("postrst_od1", 64'(a_od), 64'h32);

        // Randomized sweep against the model
        run_random(0, 3, 64'h0000_0000_FFFF_FFFF, 600);
        run_random(1, 1, 64'h0000_0000_0000_00FF, 600);
        run_random(2, 8, 64'hFFFF_FFFF_FFFF_FFFF, 600);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
